// File: rtl/argmax_pkg.sv
// Shared types and arithmetic for the output-layer argmax stage.
package argmax_pkg;
    localparam int ACC_WIDTH   = 32;
    localparam int NUM_CLASSES = 10;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Add one bit wider, then clamp when the two top bits disagree.
    function automatic logic signed [ACC_WIDTH-1:0] sat_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b
    );
        logic [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
            sat_add = s[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
        else
            sat_add = s[ACC_WIDTH-1:0];
    endfunction
endpackage

// File: rtl/digit_argmax_if.sv
// Accumulation stream from the output-layer MAC into the argmax stage.
interface digit_argmax_if
    import argmax_pkg::*;
#(
    parameter int ACC_W = ACC_WIDTH
) ();
    logic                    acc_valid;
    logic signed [ACC_W-1:0] acc_data;
    logic                    acc_ready;

    modport master (output acc_valid, output acc_data, input acc_ready);
    modport slave  (input acc_valid, input acc_data, output acc_ready);
endinterface

// File: rtl/bias_add_sat.sv
// Sign-extends and aligns a 16-bit bias, then adds it with saturation.
module bias_add_sat
    import argmax_pkg::*;
#(
    parameter int BIAS_SHIFT = 8
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    input  logic signed [15:0]          bias,
    output logic signed [ACC_WIDTH-1:0] score
);
    logic signed [ACC_WIDTH-1:0] bias_al;

    always_comb begin
        bias_al = {{(ACC_WIDTH-16){bias[15]}}, bias} << BIAS_SHIFT;
        score   = sat_add(acc, bias_al);
    end
endmodule

// File: rtl/digit_argmax.sv
// Output-layer finishing stage: bias add, running argmax, winning digit.
module digit_argmax
    import argmax_pkg::*;
#(
    parameter int ACC_W      = ACC_WIDTH,
    parameter int BIAS_SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    digit_argmax_if.slave           acc_if,
    output logic                    b23_rd,
    output logic [3:0]              b23_rdaddr,
    input  logic signed [15:0]      b23_rddata,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              digit,
    output logic signed [ACC_W-1:0] max_score
);
    state_t                  state;
    state_t                  state_nx;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        run_idx;
    logic signed [ACC_W-1:0] run_max;
    logic signed [ACC_W-1:0] score;
    logic                    hs;
    logic                    last;
    logic                    take;

    bias_add_sat #(
        .BIAS_SHIFT (BIAS_SHIFT)
    ) u_add (
        .acc   (acc_if.acc_data),
        .bias  (b23_rddata),
        .score (score)
    );

    assign hs   = acc_if.acc_valid && acc_if.acc_ready;
    assign last = (cnt == CNT_W'(NUM_CLASSES - 1));
    // Strict compare keeps the lower index on ties.
    assign take = (cnt == '0) || (score > run_max);

    always_comb begin
        state_nx         = state;
        acc_if.acc_ready = 1'b0;
        b23_rd           = 1'b0;
        b23_rdaddr       = cnt;
        busy             = 1'b0;
        done             = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = ACCUM;
            end
            ACCUM: begin
                acc_if.acc_ready = 1'b1;
                b23_rd           = 1'b1;
                busy             = 1'b1;
                if (hs && last) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            run_idx   <= '0;
            run_max   <= '0;
            digit     <= '0;
            max_score <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                cnt <= '0;
            end else if (hs) begin
                cnt <= last ? '0 : cnt + 1'b1;
                if (take) begin
                    run_max <= score;
                    run_idx <= cnt;
                end
                if (last) begin
                    digit     <= take ? cnt : run_idx;
                    max_score <= take ? score : run_max;
                end
            end
        end
    end
endmodule
